// File: rtl/screen_sequencer_pkg.sv
// Shared types for the screen sequencer: screen codes, FSM states, pixel type.
package screen_pkg;

  localparam int LVL_W = 5;

  typedef logic [1:0]  scr_t;
  typedef logic [23:0] rgb_t;

  localparam scr_t SCR_TITLE = 2'd0;
  localparam scr_t SCR_GAME  = 2'd1;
  localparam scr_t SCR_WIN   = 2'd2;
  localparam scr_t SCR_LOSE  = 2'd3;

  typedef enum logic [2:0] {
    ST_TITLE,
    ST_PLAYING,
    ST_RESULT,
    ST_FADE_OUT,
    ST_FADE_IN
  } state_t;

  // Steady state that displays a given screen.
  function automatic state_t steady_of(scr_t s);
    case (s)
      SCR_TITLE: steady_of = ST_TITLE;
      SCR_GAME:  steady_of = ST_PLAYING;
      default:   steady_of = ST_RESULT;
    endcase
  endfunction

endpackage

// File: rtl/screen_sequencer_if.sv
// Game events, source pixels and faded output of the screen sequencer.
interface screen_sequencer_if;
  import screen_pkg::*;

  logic       frame_tick;
  logic       start_btn;
  logic       win_evt;
  logic       lose_evt;
  rgb_t       title_rgb;
  rgb_t       game_rgb;
  rgb_t       win_rgb;
  rgb_t       lose_rgb;
  logic [7:0] R;
  logic [7:0] G;
  logic [7:0] B;
  scr_t       screen_sel;
  logic       game_enable;
  logic       busy;

  modport master (
    output frame_tick, start_btn, win_evt, lose_evt,
    output title_rgb, game_rgb, win_rgb, lose_rgb,
    input  R, G, B, screen_sel, game_enable, busy
  );

  modport slave (
    input  frame_tick, start_btn, win_evt, lose_evt,
    input  title_rgb, game_rgb, win_rgb, lose_rgb,
    output R, G, B, screen_sel, game_enable, busy
  );

endinterface

// File: rtl/screen_sequencer_fader.sv
// Per-channel brightness scaling (in * lvl) >> log2(FADE_STEPS), one register stage.
module rgb_fader
  import screen_pkg::*;
#(
  parameter int FADE_STEPS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  rgb_t             pix_in,
  input  logic [LVL_W-1:0] lvl,
  output rgb_t             pix_out
);

  localparam int SHIFT = $clog2(FADE_STEPS);

  // lvl never exceeds FADE_STEPS, so the shifted product always fits 8 bits.
  function automatic logic [7:0] scale(logic [7:0] c, logic [LVL_W-1:0] l);
    logic [12:0] p;
    p = 13'(c) * 13'(l);
    scale = 8'(p >> SHIFT);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_out <= '0;
    end else begin
      pix_out <= {scale(pix_in[23:16], lvl),
                  scale(pix_in[15:8],  lvl),
                  scale(pix_in[7:0],   lvl)};
    end
  end

endmodule

// File: rtl/screen_sequencer.sv
// Screen controller: picks title/game/result source, fades between screens on frame ticks.
module screen_sequencer
  import screen_pkg::*;
#(
  parameter int FADE_STEPS  = 8,
  parameter int HOLD_FRAMES = 180
) (
  input  logic               clk,
  input  logic               reset,
  screen_sequencer_if.slave  bus
);

  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FADE_STEPS);
  localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
  localparam logic [9:0]       HOLD_LAST = 10'(HOLD_FRAMES - 1);

  state_t           state, state_nx;
  scr_t             scr, scr_nx;
  scr_t             tgt, tgt_nx;
  logic [LVL_W-1:0] lvl, lvl_nx;
  logic [9:0]       hold_cnt, hold_nx;
  logic             start_prev;
  logic             start_rise;
  logic             game_enable_q;
  logic             busy_q;
  rgb_t             src_pix;
  rgb_t             out_pix;

  assign start_rise = bus.start_btn & ~start_prev;

  always_comb begin
    state_nx = state;
    scr_nx   = scr;
    tgt_nx   = tgt;
    lvl_nx   = lvl;
    hold_nx  = hold_cnt;
    case (state)
      ST_TITLE: begin
        if (start_rise) begin
          tgt_nx   = SCR_GAME;
          state_nx = ST_FADE_OUT;
        end
      end
      ST_PLAYING: begin
        if (bus.win_evt) begin
          tgt_nx   = SCR_WIN;
          state_nx = ST_FADE_OUT;
        end else if (bus.lose_evt) begin
          tgt_nx   = SCR_LOSE;
          state_nx = ST_FADE_OUT;
        end
      end
      ST_RESULT: begin
        if (start_rise || (bus.frame_tick && hold_cnt == HOLD_LAST)) begin
          tgt_nx   = SCR_TITLE;
          state_nx = ST_FADE_OUT;
        end else if (bus.frame_tick) begin
          hold_nx = hold_cnt + 10'd1;
        end
      end
      ST_FADE_OUT: begin
        if (bus.frame_tick) begin
          lvl_nx = lvl - LVL_ONE;
          // Screen swap happens only at black, inside vblank.
          if (lvl == LVL_ONE) begin
            scr_nx   = tgt;
            state_nx = ST_FADE_IN;
          end
        end
      end
      ST_FADE_IN: begin
        if (bus.frame_tick) begin
          lvl_nx = lvl + LVL_ONE;
          if (lvl == LVL_FULL - LVL_ONE) begin
            state_nx = steady_of(scr);
            hold_nx  = '0;
          end
        end
      end
      default: state_nx = ST_TITLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_TITLE;
      scr           <= SCR_TITLE;
      tgt           <= SCR_TITLE;
      lvl           <= LVL_FULL;
      hold_cnt      <= '0;
      start_prev    <= 1'b1;
      game_enable_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state         <= state_nx;
      scr           <= scr_nx;
      tgt           <= tgt_nx;
      lvl           <= lvl_nx;
      hold_cnt      <= hold_nx;
      start_prev    <= bus.start_btn;
      game_enable_q <= (state_nx == ST_PLAYING);
      busy_q        <= (state_nx == ST_FADE_OUT) || (state_nx == ST_FADE_IN);
    end
  end

  always_comb begin
    case (scr)
      SCR_TITLE: src_pix = bus.title_rgb;
      SCR_GAME:  src_pix = bus.game_rgb;
      SCR_WIN:   src_pix = bus.win_rgb;
      default:   src_pix = bus.lose_rgb;
    endcase
  end

  rgb_fader #(.FADE_STEPS(FADE_STEPS)) u_fader (
    .clk     (clk),
    .reset   (reset),
    .pix_in  (src_pix),
    .lvl     (lvl),
    .pix_out (out_pix)
  );

  assign bus.R           = out_pix[23:16];
  assign bus.G           = out_pix[15:8];
  assign bus.B           = out_pix[7:0];
  assign bus.screen_sel  = scr;
  assign bus.game_enable = game_enable_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed scenarios then random traffic, all checked against a screen/phase reference model.
module tb_screen_sequencer;
  import screen_pkg::*;

  localparam int FS = 4;
  localparam int HF = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  screen_sequencer_if sif ();

  screen_sequencer #(.FADE_STEPS(FS), .HOLD_FRAMES(HF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  int tests = 0;
  int fails = 0;

  // Model: phase 0 steady, 1 fading out, 2 fading in; steady screen implied by m_scr.
  int          m_phase, m_lvl, m_scr, m_tgt, m_hold;
  logic        m_prev;
  logic [23:0] m_pix;

  function automatic logic [23:0] scale_px(logic [23:0] p, int l);
    int r, g, b;
    r = int'(p[23:16]) * l / FS;
    g = int'(p[15:8])  * l / FS;
    b = int'(p[7:0])   * l / FS;
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  task automatic check(string tag, logic [23:0] got, logic [23:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    logic        rise;
    logic [23:0] src;
    if (reset) begin
      m_phase = 0; m_scr = 0; m_lvl = FS; m_hold = 0; m_prev = 1'b1; m_pix = '0;
    end else begin
      case (m_scr)
        0:       src = sif.title_rgb;
        1:       src = sif.game_rgb;
        2:       src = sif.win_rgb;
        default: src = sif.lose_rgb;
      endcase
      m_pix  = scale_px(src, m_lvl);
      rise   = sif.start_btn && !m_prev;
      m_prev = sif.start_btn;
      if (m_phase == 0) begin
        if (m_scr == 0 && rise) begin
          m_tgt = 1; m_phase = 1;
        end else if (m_scr == 1 && (sif.win_evt || sif.lose_evt)) begin
          m_tgt = sif.win_evt ? 2 : 3; m_phase = 1;
        end else if (m_scr >= 2) begin
          if (rise || (sif.frame_tick && m_hold == HF - 1)) begin
            m_tgt = 0; m_phase = 1;
          end else if (sif.frame_tick) begin
            m_hold++;
          end
        end
      end else if (m_phase == 1) begin
        if (sif.frame_tick) begin
          m_lvl--;
          if (m_lvl == 0) begin m_scr = m_tgt; m_phase = 2; end
        end
      end else begin
        if (sif.frame_tick) begin
          m_lvl++;
          if (m_lvl == FS) begin m_phase = 0; m_hold = 0; end
        end
      end
    end
    @(posedge clk);
    #1;
    check("pixel", {sif.R, sif.G, sif.B}, m_pix);
    check("screen_sel", 24'(sif.screen_sel), 24'(m_scr));
    check("game_enable", 24'(sif.game_enable), 24'(m_phase == 0 && m_scr == 1));
    check("busy", 24'(sif.busy), 24'(m_phase != 0));
  endtask

  task automatic tick(int gap);
    sif.frame_tick = 1'b1;
    cycle();
    sif.frame_tick = 1'b0;
    repeat (gap) cycle();
  endtask

  initial begin
    logic [7:0] exp_r [3];
    exp_r = '{8'hBF, 8'h7F, 8'h3F};

    reset          = 1'b1;
    sif.frame_tick = 1'b0;
    sif.start_btn  = 1'b0;
    sif.win_evt    = 1'b0;
    sif.lose_evt   = 1'b0;
    sif.title_rgb  = 24'hFF8040;
    sif.game_rgb   = 24'h102030;
    sif.win_rgb    = 24'h00FF00;
    sif.lose_rgb   = 24'hFF0000;

    // Reset state and passthrough.
    cycle(); cycle();
    check("reset_rgb", {sif.R, sif.G, sif.B}, 24'h0);
    check("reset_busy", 24'(sif.busy), 24'h0);
    reset = 1'b0;
    cycle();
    check("passthrough", {sif.R, sif.G, sif.B}, 24'hFF8040);
    check("passthrough_sel", 24'(sif.screen_sel), 24'h0);

    // Start from title.
    sif.start_btn = 1'b1;
    cycle();
    check("busy_after_start", 24'(sif.busy), 24'h1);
    sif.start_btn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      check("fade_out_r", 24'(sif.R), 24'(exp_r[k]));
    end
    tick(0);
    check("sel_game_at_black", 24'(sif.screen_sel), 24'h1);
    cycle();
    check("black", {sif.R, sif.G, sif.B}, 24'h0);
    repeat (4) tick(1);
    check("game_enable_on", 24'(sif.game_enable), 24'h1);
    check("busy_off", 24'(sif.busy), 24'h0);

    // Win and lose together; events during the fade are dropped.
    sif.win_evt = 1'b1; sif.lose_evt = 1'b1;
    cycle();
    sif.win_evt = 1'b0; sif.lose_evt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(0);
      sif.win_evt = (k % 2 == 0); sif.lose_evt = (k % 2 == 1);
      cycle();
      sif.win_evt = 1'b0; sif.lose_evt = 1'b0;
    end
    check("sel_victory", 24'(sif.screen_sel), 24'h2);
    repeat (4) tick(1);
    check("result_steady", 24'(sif.busy), 24'h0);

    // Automatic return after HOLD_FRAMES ticks.
    repeat (3) tick(1);
    check("auto_return_busy", 24'(sif.busy), 24'h1);
    repeat (8) tick(1);
    check("back_to_title", 24'(sif.screen_sel), 24'h0);
    check("title_idle", 24'(sif.busy), 24'h0);

    // Reset mid-fade at lvl 2, with the button still held across release.
    sif.start_btn = 1'b1;
    cycle();
    tick(1); tick(1);
    check("mid_fade_r", 24'(sif.R), 24'h7F);
    reset = 1'b1;
    cycle();
    check("midreset_rgb", {sif.R, sif.G, sif.B}, 24'h0);
    check("midreset_busy", 24'(sif.busy), 24'h0);
    reset = 1'b0;
    cycle();
    check("title_full_after_reset", {sif.R, sif.G, sif.B}, 24'hFF8040);
    repeat (3) tick(1);
    check("held_btn_no_start", 24'(sif.busy), 24'h0);
    sif.start_btn = 1'b0;
    cycle();
    sif.start_btn = 1'b1;
    cycle();
    check("fresh_edge_starts", 24'(sif.busy), 24'h1);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      reset          = ($urandom_range(0, 499) == 0);
      sif.frame_tick = ($urandom_range(0, 3) == 0);
      sif.win_evt    = ($urandom_range(0, 15) == 0);
      sif.lose_evt   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) sif.start_btn = ~sif.start_btn;
      sif.title_rgb  = 24'($urandom);
      sif.game_rgb   = 24'($urandom);
      sif.win_rgb    = 24'($urandom);
      sif.lose_rgb   = 24'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/screen_sequencer.md
# screen_sequencer

Top-level screen controller for the VGA game path. Decides which full-screen RGB source drives the DAC: title, game, victory or defeat. Switches between screens on game events with a frame-synchronous fade-out/fade-in, and holds result screens for a fixed number of frames. Sits between the per-screen pixel generators (all fed by the same `h_counter`/`v_counter`) and the VGA output registers.

## Interface
Parameters:
- `FADE_STEPS`, default 8: brightness levels per fade. Power of two, 2..16.
- `HOLD_FRAMES`, default 180: frames a result screen is shown before the automatic return to title. Range 1..1023.

Ports:
- `clk` input, 1: pixel clock.
- `reset` input, 1: reset, synchronous, active-high.
- `frame_tick` input, 1: one-cycle pulse per frame, at start of vertical blank.
- `start_btn` input, 1: debounced start button, level. Rising edge is detected internally.
- `win_evt` input, 1: one-cycle pulse when the player wins.
- `lose_evt` input, 1: one-cycle pulse when the player loses.
- `title_rgb`, `game_rgb`, `win_rgb`, `lose_rgb` input, 24 each: source pixels, `{R,G,B}`.
- `R`, `G`, `B` output, 8 each: registered, faded pixel.
- `screen_sel` output, 2: screen currently displayed. 0 title, 1 game, 2 victory, 3 defeat.
- `game_enable` output, 1: high only in steady PLAYING.
- `busy` output, 1: high in FADE_OUT and FADE_IN.

## Operation
- States:
  - Steady: TITLE, PLAYING, RESULT.
  - Transition: FADE_OUT, FADE_IN.
  - Register `target` (2 b) holds the destination screen.
- Level `lvl` (0..`FADE_STEPS`) scales the selected source.
  - Each channel: `out = (in * lvl) >> log2(FADE_STEPS)`, 13-bit intermediate.
  - `lvl = FADE_STEPS` passes the source exactly.
  - `lvl = 0` gives black.
- Start edge: `start_rise = start_btn & ~start_prev`. `start_prev` resets to 1, so a button held through reset produces no edge.
- Accepted events (steady states only):
  - TITLE + `start_rise` → target game.
  - PLAYING + `win_evt` → target victory.
  - PLAYING + `lose_evt` → target defeat.
  - PLAYING + both in the same cycle → victory (win has priority).
  - RESULT + `start_rise` → target title.
  - RESULT + `frame_tick` when `hold_cnt == HOLD_FRAMES-1` → target title.
  - On acceptance, the next state is FADE_OUT and `lvl` is unchanged.
- FADE_OUT:
  - Each `frame_tick` decrements `lvl`.
  - The tick that makes `lvl` 0 also loads `screen_sel <= target` and moves to FADE_IN.
- FADE_IN:
  - Each `frame_tick` increments `lvl`.
  - The tick that makes `lvl` `FADE_STEPS` moves to the steady state for `screen_sel` (1 → PLAYING, 2/3 → RESULT, 0 → TITLE).
- `hold_cnt` (10 b):
  - Cleared on entry to RESULT.
  - Increments on each `frame_tick` in RESULT.
  - Never wraps: the transition fires first.
- All events during FADE_OUT/FADE_IN, and events not listed above, are dropped (not queued).
- `start_prev` updates every cycle, including during fades.
- Reset, including mid-fade:
  - State TITLE, `screen_sel` 0, `lvl = FADE_STEPS`, `hold_cnt` 0.
  - `R/G/B` 0, `game_enable` 0, `busy` 0.

## Timing
- Pixel path latency is 1 cycle: `R/G/B` at cycle n+1 = scaled mux of the sources at cycle n, using `lvl`/`screen_sel` from cycle n. Upstream blanking/sync must be delayed by 1 to match.
- `screen_sel` and `lvl` change only on `frame_tick` cycles (inside vblank), so no mid-frame tearing.
- Full transition: `2*FADE_STEPS` frame_ticks after acceptance.
  - FADE_OUT: `FADE_STEPS` ticks.
  - FADE_IN: `FADE_STEPS` ticks.
- `frame_tick` in the same cycle as an accepted event: it does not count toward the fade.
- `busy` and `game_enable` are registered with the state. They reflect the state entered at the clock edge after acceptance.

## Structure
- Package `screen_pkg`:
  - Screen codes `SCR_TITLE/SCR_GAME/SCR_WIN/SCR_LOSE`.
  - State enum.
  - `rgb_t` (24 b).
- Sub-module `rgb_fader`: 24-bit in, `lvl` in, registered 24-bit out, parameter `FADE_STEPS`. Instantiated once after the source mux.
- FSM, edge detector and `hold_cnt` live in `screen_sequencer`.

## Test plan
All scenarios use `FADE_STEPS=4`, `HOLD_FRAMES=3`.
- **Reset, then pixel passthrough:** `title_rgb=0xFF8040` → next cycle `R/G/B = FF/80/40`, `screen_sel=0`, `busy=0`.
- **Start from title:** `start_btn` rises.
  - Ticks 1..3: title at `lvl` 3, 2, 1 (e.g. R = `0xBF`, `0x7F`, `0x3F`).
  - Tick 4: black, `screen_sel=1`.
  - Ticks 5..8: game fading in.
  - After tick 8: `game_enable=1`, `busy=0`.
- **Simultaneous win/lose in PLAYING:** `win_evt` and `lose_evt` in the same cycle → after 4 ticks `screen_sel=2`. Both pulses during the fade → ignored.
- **Automatic return:** in RESULT, 3 `frame_tick`s → FADE_OUT toward title. Full fade later `screen_sel=0`, state TITLE.
- **Reset mid-fade:** `reset` at `lvl=2` in FADE_OUT → next cycle TITLE, `lvl=4`, outputs 0, then title at full brightness.
- **Held button through reset:** `start_btn=1` across reset release → no transition until `start_btn` falls and rises again.
